minterm_scanner: RTL and testbench

Sequencer that exhaustively sweeps every input combination through a generated N-variable combinational logic function and extracts its minterm list. It drives the function's inputs, waits a settle interval, samples the single output, and streams the index of every true row over a valid/ready interface. It also keeps a running minterm count. It sits beside a generated SOP netlist and serves as the on-chip truth-table extractor and checker feeding the minimizer flow.

---
 rtl/minterm_scanner.sv | 136 +++++++++++++
 tb/tb_minterm_scanner.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_scanner.sv
// Exhaustive truth-table sweeper: drives every input row into a combinational
// function, samples its output and streams the indices of true rows.
module minterm_scanner #(
  parameter int unsigned N_VARS        = 12,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_VARS-1:0] func_in,
  input  logic              func_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_VARS-1:0] m_index,
  output logic              busy,
  output logic              done,
  output logic [N_VARS:0]   minterm_count
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [N_VARS-1:0] idx;
  logic [CW-1:0]     settle_cnt;

  logic idx_last;
  logic load_start;
  logic capture;
  logic handshake;
  logic advance;

  assign idx_last = &idx;

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == '0) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (func_out) begin
          capture    = 1'b1;
          state_next = EMIT;
        end else if (idx_last) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = DRIVE;
        end
      end
      EMIT: begin
        if (m_valid && m_ready) begin
          handshake = 1'b1;
          if (idx_last) begin
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = DRIVE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      func_in       <= '0;
      settle_cnt    <= '0;
      m_valid       <= 1'b0;
      m_index       <= '0;
      minterm_count <= '0;
    end else begin
      if (load_start) begin
        idx           <= '0;
        func_in       <= '0;
        minterm_count <= '0;
        settle_cnt    <= SETTLE_RELOAD;
      end
      if (state == DRIVE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (capture) begin
        m_index <= idx;
        m_valid <= 1'b1;
      end
      if (handshake) begin
        minterm_count <= minterm_count + 1'b1;
        m_valid       <= 1'b0;
      end
      if (advance) begin
        idx        <= idx + 1'b1;
        func_in    <= idx + 1'b1;
        settle_cnt <= SETTLE_RELOAD;
      end
    end
  end

  // Status flags decode straight from the state register so they clear with reset.
  assign busy = (state == DRIVE) || (state == SAMPLE) || (state == EMIT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: 12-variable sweeps against equality and
// constant functions, plus a 4-variable constant-1 sweep.
module tb_minterm_scanner;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] func_in;
  logic        func_out;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_index;
  logic        busy;
  logic        done;
  logic [12:0] minterm_count;

  logic        start4;
  logic [3:0]  func_in4;
  logic        func_out4;
  logic        m_valid4;
  logic        m_ready4;
  logic [3:0]  m_index4;
  logic        busy4;
  logic        done4;
  logic [4:0]  minterm_count4;

  int n_checks;
  int n_fail;
  int mode;        // 0 = equality, 1 = constant 0, 2 = constant 1
  int valid_seen;

  logic [11:0] hs_q[$];
  logic [3:0]  hs4_q[$];

  minterm_scanner #(.N_VARS(12), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_in(func_in),
    .func_out(func_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_index(m_index), .busy(busy), .done(done), .minterm_count(minterm_count)
  );

  minterm_scanner #(.N_VARS(4), .SETTLE_CYCLES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .func_in(func_in4),
    .func_out(func_out4), .m_valid(m_valid4), .m_ready(m_ready4),
    .m_index(m_index4), .busy(busy4), .done(done4), .minterm_count(minterm_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    func_out = 1'b0;
    if (mode == 0) func_out = (func_in[11:6] == func_in[5:0]);
    else if (mode == 2) func_out = 1'b1;
  end

  assign func_out4 = 1'b1;

  always @(posedge clk) begin
    if (m_valid) valid_seen <= valid_seen + 1;
    if (m_valid && m_ready) hs_q.push_back(m_index);
    if (m_valid4 && m_ready4) hs4_q.push_back(m_index4);
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; m_ready = 1'b1; m_ready4 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({func_in, m_valid, m_index, busy, done, minterm_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got func_in=%h m_valid=%b m_index=%h busy=%b done=%b count=%0d, want all 0",
               func_in, m_valid, m_index, busy, done, minterm_count);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_equality();
    bit ok;
    mode = 0; m_ready = 1'b1; hs_q.delete();
    pulse_start();
    wait_done(10000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL eq_done_timeout: done not seen within 10000 cycles, want done");
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL eq_busy_in_done: got busy=%b, want 0", busy);
    end
    n_checks++;
    if (minterm_count !== 13'd64) begin
      n_fail++;
      $display("FAIL eq_count: got %0d, want 64", minterm_count);
    end
    n_checks++;
    if (hs_q.size() != 64) begin
      n_fail++;
      $display("FAIL eq_hs_count: got %0d handshakes, want 64", hs_q.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        logic [11:0] expv;
        expv = 12'(k * 65);
        if (hs_q[k] !== expv) begin
          n_fail++;
          $display("FAIL eq_index[%0d]: got %h, want %h", k, hs_q[k], expv);
          break;
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL eq_done_pulse: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_const0();
    bit ok;
    int n;
    mode = 1; m_ready = 1'b1; valid_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL c0_busy_before: got busy=%b in start cycle, want 0", busy);
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL c0_busy_rise: got busy=%b, want 1", busy);
    end
    n = 0; ok = 1'b0;
    while (n < 9000) begin
      @(negedge clk);
      n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || n != 8192) begin
      n_fail++;
      $display("FAIL c0_latency: got done after %0d cycles (seen=%b), want 8192", n, ok);
    end
    n_checks++;
    if (valid_seen != 0 || minterm_count !== 13'd0) begin
      n_fail++;
      $display("FAIL c0_no_minterms: got valid_cycles=%0d count=%0d, want 0 and 0", valid_seen, minterm_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int t;
    mode = 0; m_ready = 1'b0; hs_q.delete();
    pulse_start();
    t = 0;
    while (!m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!m_valid) begin
      n_fail++;
      $display("FAIL bp_first_valid: got m_valid=0 after 20 cycles, want 1");
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_index !== 12'h000 || func_in !== 12'h000 || minterm_count !== 13'd0) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got valid=%b idx=%h func_in=%h count=%0d, want 1 000 000 0",
                 i, m_valid, m_index, func_in, minterm_count);
      end
      if (i < 4) @(negedge clk);
    end
    #1 m_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (minterm_count !== 13'd1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_handshake: got count=%0d valid=%b, want 1 0", minterm_count, m_valid);
    end
    wait_done(10000, ok);
    n_checks++;
    if (!ok || minterm_count !== 13'd64 || hs_q.size() != 64) begin
      n_fail++;
      $display("FAIL bp_final: got done=%b count=%0d hs=%0d, want 1 64 64", ok, minterm_count, hs_q.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        logic [11:0] expv;
        expv = 12'(k * 65);
        if (hs_q[k] !== expv) begin
          n_fail++;
          $display("FAIL bp_index[%0d]: got %h, want %h", k, hs_q[k], expv);
          break;
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int t;
    mode = 0; m_ready = 1'b1; hs_q.delete();
    pulse_start();
    t = 0;
    while (func_in !== 12'h010 && t < 200) begin
      @(negedge clk);
      t++;
    end
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (func_in < 12'h010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL si_no_restart: got func_in=%h busy=%b, want >=010 and 1", func_in, busy);
    end
    wait_done(10000, ok);
    n_checks++;
    if (!ok || minterm_count !== 13'd64 || hs_q.size() != 64) begin
      n_fail++;
      $display("FAIL si_final: got done=%b count=%0d hs=%0d, want 1 64 64", ok, minterm_count, hs_q.size());
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL si_idle_after: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    mode = 0; m_ready = 1'b1;
    pulse_start();
    t = 0;
    while (func_in !== 12'h100 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({func_in, m_valid, m_index, busy, done, minterm_count} !== '0) begin
      n_fail++;
      $display("FAIL rm_async: got func_in=%h valid=%b idx=%h busy=%b done=%b count=%0d, want all 0",
               func_in, m_valid, m_index, busy, done, minterm_count);
    end
    #1 rst_n = 1'b1;
    hs_q.delete();
    pulse_start();
    wait_done(10000, ok);
    n_checks++;
    if (!ok || minterm_count !== 13'd64 || hs_q.size() != 64 || hs_q[0] !== 12'h000) begin
      n_fail++;
      $display("FAIL rm_rescan: got done=%b count=%0d hs=%0d, want 1 64 64 from 000", ok, minterm_count, hs_q.size());
    end
  endtask

  task automatic test_const1_n4();
    bit ok;
    m_ready4 = 1'b1; hs4_q.delete();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done4) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || minterm_count4 !== 5'h10) begin
      n_fail++;
      $display("FAIL c1_count: got done=%b count=%h, want 1 10", ok, minterm_count4);
    end
    n_checks++;
    if (hs4_q.size() != 16) begin
      n_fail++;
      $display("FAIL c1_hs_count: got %0d, want 16", hs4_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (hs4_q[k] !== 4'(k)) begin
          n_fail++;
          $display("FAIL c1_index[%0d]: got %h, want %h", k, hs4_q[k], 4'(k));
          break;
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; mode = 0; valid_seen = 0;
    test_reset();
    test_equality();
    test_const0();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_const1_n4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
